adder_32_mp_seq: RTL and testbench

Multi-precision add/subtract sequencer that time-shares one external combinational 32-bit adder (ports in1, in2, cin → sum, cout). It accepts two WORDS×32-bit operands and feeds them to the adder one 32-bit word per cycle, LSW first, chaining the carry through a register. It assembles the wide result and reports the final carry. It sits between a requester (start/done handshake) and the shared adder instance.

---
 rtl/adder_32_mp_seq.sv | 128 ++++++++++++
 tb/tb_adder_32_mp_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_32_mp_seq.sv
// Multi-precision add/subtract sequencer. Streams two WORDS x 32-bit operands
// through one shared external 32-bit adder, LSW first, chaining the carry
// through a register, and assembles the wide result.
module adder_32_mp_seq #(
    parameter int unsigned WORDS = 4,
    parameter int unsigned IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin_in,
    input  logic [32*WORDS-1:0]   op_a,
    input  logic [32*WORDS-1:0]   op_b,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   result,
    output logic                  cout_out,
    output logic [31:0]           add_in1,
    output logic [31:0]           add_in2,
    output logic                  add_cin,
    input  logic [31:0]           add_sum,
    input  logic                  add_cout
);

    localparam int unsigned W = 32 * WORDS;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic [W-1:0]    r_result;
    logic            r_cout;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;

    int unsigned     w_base;
    logic            w_last;
    logic [31:0]     w_a_word;
    logic [31:0]     w_b_word;

    assign w_base   = 32 * 32'(r_idx);
    assign w_last   = (r_idx == IDXW'(WORDS - 1));
    assign w_a_word = r_a[w_base +: 32];
    // Subtraction is A + ~B + 1; the +1 comes from the forced initial carry.
    assign w_b_word = r_b[w_base +: 32] ^ {32{r_sub}};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> RUN for WORDS cycles -> DONE for one cycle -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_nxt = StRun;
            StRun:   if (w_last) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Datapath: latch operands on accept, then fold one adder word per RUN cycle.
    // add_sum/add_cout are only looked at in RUN so junk elsewhere cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_sub    <= sub;
                        r_carry  <= sub | cin_in;
                        r_idx    <= '0;
                        r_result <= '0;
                    end
                end
                StRun: begin
                    r_result[w_base +: 32] <= add_sum;
                    r_carry                <= add_cout;
                    if (w_last) begin
                        r_cout <= add_cout;
                        r_idx  <= '0;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status and shared-adder drive; adder inputs held at zero outside RUN.
    always_comb begin
        ready   = (r_state == StIdle);
        busy    = (r_state == StRun);
        done    = (r_state == StDone);
        add_in1 = '0;
        add_in2 = '0;
        add_cin = 1'b0;
        if (r_state == StRun) begin
            add_in1 = w_a_word;
            add_in2 = w_b_word;
            add_cin = r_carry;
        end
    end

    assign result   = r_result;
    assign cout_out = r_cout;

endmodule

// File: tb/tb_adder_32_mp_seq.sv
// Self-checking bench for adder_32_mp_seq: wide-arithmetic reference model,
// per-cycle compare process, and directed vectors with literal expectations.
module tb_adder_32_mp_seq;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           sub;
    logic           cin_in;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           cout_out;
    logic [31:0]    add_in1;
    logic [31:0]    add_in2;
    logic           add_cin;
    logic [31:0]    add_sum;
    logic           add_cout;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    adder_32_mp_seq #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .cin_in   (cin_in),
        .op_a     (op_a),
        .op_b     (op_b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout_out (cout_out),
        .add_in1  (add_in1),
        .add_in2  (add_in2),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Reference model state: phase 0 idle, 1..WORDS run, WORDS+1 done.
    int           m_phase;
    logic [W-1:0] m_a;
    logic [W-1:0] m_bp;
    logic         m_c0;
    logic [W:0]   m_full;
    logic [W-1:0] m_hold_res;
    logic         m_hold_cout;

    // Shared adder: real sum only while the model says RUN, junk otherwise.
    logic [32:0] w_full;
    always_comb begin
        if (m_phase >= 1 && m_phase <= WORDS)
            w_full = {1'b0, add_in1} + {1'b0, add_in2} + 33'(add_cin);
        else
            w_full = 33'h1_DEADBEEF;
    end
    assign add_sum  = w_full[31:0];
    assign add_cout = w_full[32];

    function automatic logic [W:0] wide_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic c);
        logic [W-1:0] bp;
        bp = s ? ~b : b;
        return {1'b0, a} + {1'b0, bp} + (W+1)'(s ? 1'b1 : c);
    endfunction

    // Carry entering word j = carry out of the low 32*j bits of the wide sum.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] bp,
                                        input logic c0, input int j);
        logic [W:0] mask;
        logic [W:0] s;
        mask = ((W+1)'(1) << (32 * j)) - 1;
        s    = ({1'b0, a} & mask) + ({1'b0, bp} & mask) + (W+1)'(c0);
        return s[32 * j];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase     <= 0;
            m_a         <= '0;
            m_bp        <= '0;
            m_c0        <= 1'b0;
            m_full      <= '0;
            m_hold_res  <= '0;
            m_hold_cout <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_a     <= op_a;
                m_bp    <= sub ? ~op_b : op_b;
                m_c0    <= sub ? 1'b1 : cin_in;
                m_full  <= wide_op(op_a, op_b, sub, cin_in);
                m_phase <= 1;
            end
        end else if (m_phase <= WORDS) begin
            m_phase <= m_phase + 1;
            if (m_phase == WORDS) begin
                m_hold_res  <= m_full[W-1:0];
                m_hold_cout <= m_full[W];
            end
        end else begin
            m_phase <= 0;
        end
    end

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int           c;
        logic         run;
        logic [W-1:0] mask;
        logic [W-1:0] exp_res;
        c   = m_phase;
        run = (c >= 1 && c <= WORDS);
        chk("ready", (W+1)'(ready), (W+1)'(c == 0));
        chk("busy",  (W+1)'(busy),  (W+1)'(run));
        chk("done",  (W+1)'(done),  (W+1)'(c == WORDS + 1));
        if (run) begin
            chk("add_in1", (W+1)'(add_in1), (W+1)'(m_a[32*(c-1) +: 32]));
            chk("add_in2", (W+1)'(add_in2), (W+1)'(m_bp[32*(c-1) +: 32]));
            chk("add_cin", (W+1)'(add_cin), (W+1)'(carry_into(m_a, m_bp, m_c0, c - 1)));
            mask    = (W'(1) << (32 * (c - 1))) - 1;
            exp_res = m_full[W-1:0] & mask;
        end else begin
            chk("add_idle", (W+1)'({add_in1, add_in2, add_cin}), '0);
            exp_res = m_hold_res;
        end
        chk("result",   (W+1)'(result),   (W+1)'(exp_res));
        chk("cout_out", (W+1)'(cout_out), (W+1)'(m_hold_cout));
    end

    // One request; checks latency and the literal expected result.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input logic [W-1:0] er,
                          input logic ec);
        int n;
        @(posedge clk);
        #1;
        op_a = a; op_b = b; sub = s; cin_in = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble inputs mid-operation; they must not matter.
        op_a = ~a; op_b = ~b; sub = ~s; cin_in = ~c;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        chk({nm, "_latency"}, (W+1)'(n), (W+1)'(5));
        chk({nm, "_result"}, (W+1)'(result), (W+1)'(er));
        chk({nm, "_cout"}, (W+1)'(cout_out), (W+1)'(ec));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   rs;
        int           ndone;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin_in = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", (W+1)'(result), '0);
        chk("rst_ready",  (W+1)'(ready),  (W+1)'(1));
        rst_n = 1'b1;

        run_op("ripple", 128'hFFFFFFFF, 128'h1, 1'b0, 1'b0, 128'h1_00000000, 1'b0);
        run_op("ovf0", {W{1'b1}}, 128'h1, 1'b0, 1'b0, 128'h0, 1'b1);
        run_op("ovf1", {W{1'b1}}, 128'h1, 1'b0, 1'b1, 128'h1, 1'b1);
        run_op("sub_borrow", 128'h0, 128'h1, 1'b1, 1'b0, {W{1'b1}}, 1'b0);
        run_op("sub_nb", 128'h5_00000000_00000000_00000003, 128'h3, 1'b1, 1'b1,
               128'h5_00000000_00000000_00000000, 1'b1);

        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rs = {1'b0, ra} + {1'b0, rb} + (W+1)'(i[0]);
            run_op("rand_add", ra, rb, 1'b0, i[0], rs[W-1:0], rs[W]);
        end

        // start held high: one acceptance per WORDS+2 cycles, inputs churning.
        @(posedge clk);
        #1;
        start = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (done) ndone++;
            #1;
            op_a   = {$urandom, $urandom, $urandom, $urandom};
            op_b   = {$urandom, $urandom, $urandom, $urandom};
            sub    = 1'($urandom);
            cin_in = 1'($urandom);
        end
        start = 1'b0;
        chk("hold_start_dones", (W+1)'(ndone), (W+1)'(4));

        // Reset during RUN cycle 2.
        @(posedge clk);
        #1;
        op_a = 128'h1234; op_b = 128'h5678; sub = 1'b0; cin_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready",  (W+1)'(ready),    (W+1)'(1));
        chk("abort_busy",   (W+1)'(busy),     '0);
        chk("abort_done",   (W+1)'(done),     '0);
        chk("abort_result", (W+1)'(result),   '0);
        chk("abort_cout",   (W+1)'(cout_out), '0);
        chk("abort_adder",  (W+1)'({add_in1, add_in2, add_cin}), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op("post_rst", {32{4'hA}}, {32{4'h5}}, 1'b0, 1'b1, 128'h0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
